sume_ipif_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one IPIF register-bus slave (Bus2IP_*/IP2Bus_*) among
//  NUM_REQ local requesters, e.g. the host AXI-Lite bridge and an internal config sequencer.

---
 rtl/sume_ipif_rr_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_sume_ipif_rr_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sume_ipif_rr_arbiter.sv
// Round-robin arbiter sharing one IPIF register slave among NUM_REQ local requesters.
// Serialises transactions, edge-detects slave acks and times out a silent slave.
module sume_ipif_rr_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned C_ADDR_WIDTH   = 32,
    parameter int unsigned C_DATA_WIDTH   = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                                Bus2IP_Clk,
    input  logic                                Bus2IP_Reset,
    input  logic [NUM_REQ-1:0]                  Req_CS,
    input  logic [NUM_REQ-1:0]                  Req_RNW,
    input  logic [NUM_REQ*C_ADDR_WIDTH-1:0]     Req_Addr,
    input  logic [NUM_REQ*C_DATA_WIDTH-1:0]     Req_Data,
    input  logic [NUM_REQ*(C_DATA_WIDTH/8)-1:0] Req_BE,
    output logic [C_DATA_WIDTH-1:0]             Req_RdData,
    output logic [NUM_REQ-1:0]                  Req_RdAck,
    output logic [NUM_REQ-1:0]                  Req_WrAck,
    output logic [NUM_REQ-1:0]                  Req_Error,
    output logic [NUM_REQ-1:0]                  Arb_Grant,
    output logic [C_ADDR_WIDTH-1:0]             Bus2IP_Addr,
    output logic                                Bus2IP_CS,
    output logic                                Bus2IP_RNW,
    output logic [C_DATA_WIDTH-1:0]             Bus2IP_Data,
    output logic [C_DATA_WIDTH/8-1:0]           Bus2IP_BE,
    input  logic [C_DATA_WIDTH-1:0]             IP2Bus_Data,
    input  logic                                IP2Bus_RdAck,
    input  logic                                IP2Bus_WrAck,
    input  logic                                IP2Bus_Error
);
    localparam int          NR = NUM_REQ;
    localparam int unsigned AW = C_ADDR_WIDTH;
    localparam int unsigned DW = C_DATA_WIDTH;
    localparam int unsigned BW = C_DATA_WIDTH / 8;
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StResp, StTurn} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [TW-1:0]     tcnt_q, tcnt_d, tcnt_inc;
    logic              rdack_q, wrack_q;
    logic [NR-1:0]     gnt_q, gnt_d;
    logic [AW-1:0]     b_addr_q, b_addr_d;
    logic              b_cs_q, b_cs_d;
    logic              b_rnw_q, b_rnw_d;
    logic [DW-1:0]     b_data_q, b_data_d;
    logic [BW-1:0]     b_be_q, b_be_d;
    logic [NR-1:0]     req_rdack_q, req_rdack_d;
    logic [NR-1:0]     req_wrack_q, req_wrack_d;
    logic [NR-1:0]     req_err_q, req_err_d;
    logic [DW-1:0]     req_rddata_q, req_rddata_d;

    logic              found, found_hi, found_lo;
    logic [IW-1:0]     win, win_hi, win_lo;
    logic [NR-1:0]     gnt_win;
    logic [AW-1:0]     sel_addr;
    logic              sel_rnw;
    logic [DW-1:0]     sel_data;
    logic [BW-1:0]     sel_be;
    logic              ack_ok, tmo;

    // Search above the pointer first, then wrap to the low indices.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int j = 0; j < NR; j++) begin
            if (Req_CS[j]) begin
                if (j > int'(ptr_q)) begin
                    if (!found_hi) begin
                        found_hi = 1'b1;
                        win_hi   = IW'(j);
                    end
                end else if (!found_lo) begin
                    found_lo = 1'b1;
                    win_lo   = IW'(j);
                end
            end
        end
        found = found_hi | found_lo;
        win   = found_hi ? win_hi : win_lo;
    end

    always_comb begin
        gnt_win  = '0;
        sel_addr = '0;
        sel_rnw  = 1'b0;
        sel_data = '0;
        sel_be   = '0;
        for (int j = 0; j < NR; j++) begin
            if (win == IW'(j)) begin
                gnt_win[j] = 1'b1;
                sel_addr   = Req_Addr[j*AW +: AW];
                sel_rnw    = Req_RNW[j];
                sel_data   = Req_Data[j*DW +: DW];
                sel_be     = Req_BE[j*BW +: BW];
            end
        end
    end

    // Only a rising edge in the transaction's direction counts as an ack.
    assign ack_ok   = b_rnw_q ? (IP2Bus_RdAck & ~rdack_q) : (IP2Bus_WrAck & ~wrack_q);
    assign tcnt_inc = tcnt_q + 1'b1;
    assign tmo      = (TIMEOUT_CYCLES != 0) && (tcnt_inc == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (found) state_d = StBusy;
            StBusy:  if (ack_ok || tmo) state_d = StResp;
            StResp:  state_d = StTurn;
            StTurn:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ptr_d        = ptr_q;
        tcnt_d       = tcnt_q;
        gnt_d        = gnt_q;
        b_addr_d     = b_addr_q;
        b_cs_d       = b_cs_q;
        b_rnw_d      = b_rnw_q;
        b_data_d     = b_data_q;
        b_be_d       = b_be_q;
        req_rdack_d  = '0;
        req_wrack_d  = '0;
        req_err_d    = '0;
        req_rddata_d = req_rddata_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    ptr_d    = win;
                    gnt_d    = gnt_win;
                    tcnt_d   = '0;
                    b_cs_d   = 1'b1;
                    b_addr_d = sel_addr;
                    b_rnw_d  = sel_rnw;
                    b_data_d = sel_rnw ? '0 : sel_data;
                    b_be_d   = sel_rnw ? '0 : sel_be;
                end
            end
            StBusy: begin
                tcnt_d = tcnt_inc;
                if (ack_ok || tmo) begin
                    tcnt_d      = '0;
                    b_cs_d      = 1'b0;
                    b_addr_d    = '0;
                    b_rnw_d     = 1'b0;
                    b_data_d    = '0;
                    b_be_d      = '0;
                    req_rdack_d = b_rnw_q ? gnt_q : '0;
                    req_wrack_d = b_rnw_q ? '0 : gnt_q;
                    if (ack_ok) begin
                        req_err_d = IP2Bus_Error ? gnt_q : '0;
                        if (b_rnw_q) req_rddata_d = IP2Bus_Data;
                    end else begin
                        req_err_d    = gnt_q;
                        req_rddata_d = '0;
                    end
                end
            end
            StResp:  gnt_d = '0;
            default: ;
        endcase
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            ptr_q        <= IW'(NR - 1);
            tcnt_q       <= '0;
            rdack_q      <= 1'b0;
            wrack_q      <= 1'b0;
            gnt_q        <= '0;
            b_addr_q     <= '0;
            b_cs_q       <= 1'b0;
            b_rnw_q      <= 1'b0;
            b_data_q     <= '0;
            b_be_q       <= '0;
            req_rdack_q  <= '0;
            req_wrack_q  <= '0;
            req_err_q    <= '0;
            req_rddata_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            tcnt_q       <= tcnt_d;
            rdack_q      <= IP2Bus_RdAck;
            wrack_q      <= IP2Bus_WrAck;
            gnt_q        <= gnt_d;
            b_addr_q     <= b_addr_d;
            b_cs_q       <= b_cs_d;
            b_rnw_q      <= b_rnw_d;
            b_data_q     <= b_data_d;
            b_be_q       <= b_be_d;
            req_rdack_q  <= req_rdack_d;
            req_wrack_q  <= req_wrack_d;
            req_err_q    <= req_err_d;
            req_rddata_q <= req_rddata_d;
        end
    end

    assign Req_RdData  = req_rddata_q;
    assign Req_RdAck   = req_rdack_q;
    assign Req_WrAck   = req_wrack_q;
    assign Req_Error   = req_err_q;
    assign Arb_Grant   = gnt_q;
    assign Bus2IP_Addr = b_addr_q;
    assign Bus2IP_CS   = b_cs_q;
    assign Bus2IP_RNW  = b_rnw_q;
    assign Bus2IP_Data = b_data_q;
    assign Bus2IP_BE   = b_be_q;

endmodule

// File: tb/tb_sume_ipif_rr_arbiter.sv
// Bench for sume_ipif_rr_arbiter: directed requester/slave stimulus with a
// scoreboard of expected requester responses checked by an independent monitor.
module tb_sume_ipif_rr_arbiter;

    typedef struct packed {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic [1:0]  err;
        logic [31:0] data;
        logic [1:0]  gnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        Bus2IP_Reset;
    logic [1:0]  Req_CS, Req_RNW;
    logic [63:0] Req_Addr, Req_Data;
    logic [7:0]  Req_BE;
    logic [31:0] Req_RdData;
    logic [1:0]  Req_RdAck, Req_WrAck, Req_Error, Arb_Grant;
    logic [31:0] Bus2IP_Addr, Bus2IP_Data, IP2Bus_Data;
    logic        Bus2IP_CS, Bus2IP_RNW;
    logic [3:0]  Bus2IP_BE;
    logic        IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error;

    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    logic [31:0] model_rd = '0;

    // Slave behaviour: 0 = ack after delay, 1 = never ack, 2 = wrong-direction pulse first
    int          slv_mode = 0;
    int          slv_delay = 0;
    int          slv_hold = 1;
    logic        slv_err = 1'b0;
    logic [31:0] slv_rdata = '0;

    int          lat0, lat1;

    sume_ipif_rr_arbiter #(
        .NUM_REQ        (2),
        .C_ADDR_WIDTH   (32),
        .C_DATA_WIDTH   (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .Bus2IP_Clk   (clk),
        .Bus2IP_Reset (Bus2IP_Reset),
        .Req_CS       (Req_CS),
        .Req_RNW      (Req_RNW),
        .Req_Addr     (Req_Addr),
        .Req_Data     (Req_Data),
        .Req_BE       (Req_BE),
        .Req_RdData   (Req_RdData),
        .Req_RdAck    (Req_RdAck),
        .Req_WrAck    (Req_WrAck),
        .Req_Error    (Req_Error),
        .Arb_Grant    (Arb_Grant),
        .Bus2IP_Addr  (Bus2IP_Addr),
        .Bus2IP_CS    (Bus2IP_CS),
        .Bus2IP_RNW   (Bus2IP_RNW),
        .Bus2IP_Data  (Bus2IP_Data),
        .Bus2IP_BE    (Bus2IP_BE),
        .IP2Bus_Data  (IP2Bus_Data),
        .IP2Bus_RdAck (IP2Bus_RdAck),
        .IP2Bus_WrAck (IP2Bus_WrAck),
        .IP2Bus_Error (IP2Bus_Error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({Bus2IP_Addr, Bus2IP_CS, Bus2IP_RNW, Bus2IP_Data, Bus2IP_BE, Arb_Grant,
                     Req_RdAck, Req_WrAck, Req_Error, Req_RdData});
    endfunction

    task automatic push_exp(input int r, input logic rd, input logic err, input logic [31:0] rdata);
        exp_t       e;
        logic [1:0] oh;
        oh    = '0;
        oh[r] = 1'b1;
        if (rd) model_rd = rdata;
        e.rd   = rd ? oh : 2'b00;
        e.wr   = rd ? 2'b00 : oh;
        e.err  = err ? oh : 2'b00;
        e.data = model_rd;
        e.gnt  = oh;
        sb.push_back(e);
    endtask

    // One requester transaction: raise CS, wait for its ack, drop CS the cycle after.
    task automatic req_txn(input int r, input logic rnw, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be, output int lat);
        int n;
        Req_RNW[r]          = rnw;
        Req_Addr[r*32 +: 32] = addr;
        Req_Data[r*32 +: 32] = data;
        Req_BE[r*4 +: 4]     = be;
        Req_CS[r]           = 1'b1;
        n = 0;
        while (!(Req_RdAck[r] | Req_WrAck[r]) && n < 200) begin
            tick();
            n++;
        end
        lat = n;
        if (n >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack_wait req%0d: got no ack within %0d cycles, expected an ack", r, n);
            Req_CS[r] = 1'b0;
        end else begin
            check("cs_low_in_resp", 128'(Bus2IP_CS), 128'(0));
            tick();
            Req_CS[r] = 1'b0;
            check("cs_grant_low_in_turn", 128'({Bus2IP_CS, Arb_Grant}), 128'(0));
        end
    endtask

    // Slave model
    initial begin
        logic rnw_s;
        IP2Bus_Data  = '0;
        IP2Bus_RdAck = 1'b0;
        IP2Bus_WrAck = 1'b0;
        IP2Bus_Error = 1'b0;
        forever begin
            tick();
            if (Bus2IP_CS) begin
                rnw_s = Bus2IP_RNW;
                if (slv_mode != 1) begin
                    repeat (slv_delay) tick();
                    if (slv_mode == 2) begin
                        if (rnw_s) IP2Bus_WrAck = 1'b1;
                        else       IP2Bus_RdAck = 1'b1;
                        tick();
                        IP2Bus_RdAck = 1'b0;
                        IP2Bus_WrAck = 1'b0;
                        tick();
                    end
                    IP2Bus_Data  = rnw_s ? slv_rdata : 32'h0;
                    IP2Bus_Error = slv_err;
                    if (rnw_s) IP2Bus_RdAck = 1'b1;
                    else       IP2Bus_WrAck = 1'b1;
                    repeat (slv_hold) tick();
                    IP2Bus_RdAck = 1'b0;
                    IP2Bus_WrAck = 1'b0;
                    IP2Bus_Error = 1'b0;
                    IP2Bus_Data  = '0;
                end
                while (Bus2IP_CS) tick();
            end
        end
    end

    // Monitor: every ack pulse must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        got = {Req_RdAck, Req_WrAck, Req_Error, Req_RdData, Arb_Grant};
        if (|(Req_RdAck | Req_WrAck)) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ack: got %0h, expected no ack", got);
            end else begin
                e = sb.pop_front();
                check("scoreboard_ack", 128'(got), 128'(e));
            end
        end else begin
            check("error_outside_ack", 128'(Req_Error), 128'(0));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200us, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Bus2IP_Reset = 1'b1;
        Req_CS   = '0;
        Req_RNW  = '0;
        Req_Addr = '0;
        Req_Data = '0;
        Req_BE   = '0;
        repeat (2) tick();
        check("reset_state", all_outs(), 128'(0));
        Bus2IP_Reset = 1'b0;
        repeat (2) tick();

        // Write with slave ack two cycles after CS
        slv_mode = 0; slv_delay = 2; slv_hold = 1; slv_err = 1'b0;
        push_exp(0, 1'b0, 1'b0, 32'h0);
        fork
            req_txn(0, 1'b0, 32'h10, 32'hCAFEF00D, 4'hF, lat0);
            begin
                tick();
                check("t1_cs_and_grant", 128'({Bus2IP_CS, Arb_Grant}), 128'({1'b1, 2'b01}));
                check("t1_bus_fields", 128'({Bus2IP_Addr, Bus2IP_Data, Bus2IP_BE, Bus2IP_RNW}),
                      128'({32'h10, 32'hCAFEF00D, 4'hF, 1'b0}));
            end
        join
        check("t1_ack_latency", 128'(lat0), 128'(4));
        repeat (4) tick();

        // Read with the slave ack held high for five cycles
        slv_delay = 0; slv_hold = 5; slv_rdata = 32'h12345678;
        push_exp(0, 1'b1, 1'b0, 32'h12345678);
        fork
            req_txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, lat0);
            begin
                tick();
                check("t2_read_fields", 128'({Bus2IP_CS, Bus2IP_RNW, Bus2IP_Addr, Bus2IP_Data,
                      Bus2IP_BE}), 128'({1'b1, 1'b1, 32'h20, 32'h0, 4'h0}));
            end
        join
        check("t2_ack_latency", 128'(lat0), 128'(2));
        repeat (8) tick();

        // Write with a wrong-direction RdAck pulse before the WrAck
        slv_mode = 2; slv_delay = 0; slv_hold = 1;
        push_exp(1, 1'b0, 1'b0, 32'h0);
        req_txn(1, 1'b0, 32'h30, 32'h0F0F0F0F, 4'h3, lat1);
        check("t5_ack_latency", 128'(lat1), 128'(4));
        repeat (4) tick();

        // Contention: req0 reads, req1 writes, three each, alternating from req0
        slv_mode = 0; slv_rdata = 32'h0BADBEEF;
        for (int k = 0; k < 3; k++) begin
            push_exp(0, 1'b1, 1'b0, 32'h0BADBEEF);
            push_exp(1, 1'b0, 1'b0, 32'h0);
        end
        fork
            for (int k = 0; k < 3; k++) begin
                req_txn(0, 1'b1, 32'h40 + 32'(k), 32'h0, 4'h0, lat0);
                tick();
            end
            for (int k = 0; k < 3; k++) begin
                req_txn(1, 1'b0, 32'h80 + 32'(k), 32'hA0 + 32'(k), 4'hF, lat1);
                tick();
            end
        join
        repeat (4) tick();

        // Timeout on a silent slave, then a normal read and an error write
        slv_mode = 1;
        push_exp(0, 1'b1, 1'b1, 32'h0);
        req_txn(0, 1'b1, 32'h50, 32'h0, 4'h0, lat0);
        check("t4_timeout_latency", 128'(lat0), 128'(17));
        repeat (4) tick();
        slv_mode = 0; slv_rdata = 32'h5555AAAA;
        push_exp(1, 1'b1, 1'b0, 32'h5555AAAA);
        req_txn(1, 1'b1, 32'h54, 32'h0, 4'h0, lat1);
        check("t4_followup_latency", 128'(lat1), 128'(2));
        repeat (4) tick();
        slv_err = 1'b1;
        push_exp(0, 1'b0, 1'b1, 32'h0);
        req_txn(0, 1'b0, 32'h58, 32'h11112222, 4'hC, lat0);
        slv_err = 1'b0;
        repeat (4) tick();

        // Reset in the middle of a write; the in-flight request gets no ack
        slv_mode = 1;
        Req_RNW[0]       = 1'b0;
        Req_Addr[31:0]   = 32'h60;
        Req_Data[31:0]   = 32'hDEADBEEF;
        Req_BE[3:0]      = 4'hF;
        Req_CS[0]        = 1'b1;
        tick();
        check("t6_cs_before_reset", 128'({Bus2IP_CS, Arb_Grant}), 128'({1'b1, 2'b01}));
        repeat (2) tick();
        Bus2IP_Reset = 1'b1;
        tick();
        check("t6_outputs_after_reset", all_outs(), 128'(0));
        Bus2IP_Reset = 1'b0;
        Req_CS[0]    = 1'b0;
        model_rd     = 32'h0;
        repeat (4) tick();

        // Pointer back at its reset value: req0 wins the first contention
        slv_mode = 0; slv_rdata = 32'h77778888;
        push_exp(0, 1'b1, 1'b0, 32'h77778888);
        push_exp(1, 1'b0, 1'b0, 32'h0);
        fork
            req_txn(0, 1'b1, 32'h70, 32'h0, 4'h0, lat0);
            req_txn(1, 1'b0, 32'h74, 32'h33334444, 4'hF, lat1);
        join
        repeat (6) tick();
        check("scoreboard_drained", 128'(sb.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
